mux_pair_driver: RTL and testbench
==================================

Name: mux_pair_driver

Overview:
- Command-side initiator for the dual-lane 8-bit select mux unit.
- Lane 0 selects data / 0x01 / 0x02 / 0x03; lane 1 selects data / 0x04 / 0x05 / 0x06.
- Accepts one command per transaction over valid/ready, drives registered select and data lines into the mux unit, and waits a programmable settle window (timing-tutorial multicycle path).
- Captures both mux outputs, checks them against the expected values, and returns the result over a second valid/ready interface.

Parameters:
WIDTH, 8, data width of both lanes and of all data/result ports
SETTLE_CYCLES, 2, cycles from command acceptance to output capture; legal range 1..15

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_sel0  input  2  lane 0 select code
cmd_sel1  input  2  lane 1 select code
cmd_data0  input  WIDTH  lane 0 data operand
cmd_data1  input  WIDTH  lane 1 data operand
mux_sel_0  output  2  to mux unit lane 0 select
mux_sel_1  output  2  to mux unit lane 1 select
mux_in_0  output  WIDTH  to mux unit lane 0 data
mux_in_1  output  WIDTH  to mux unit lane 1 data
mux_out_0  input  WIDTH  from mux unit lane 0 result
mux_out_1  input  WIDTH  from mux unit lane 1 result
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data0  output  WIDTH  captured lane 0 result
rsp_data1  output  WIDTH  captured lane 1 result
rsp_err0  output  1  lane 0 captured value != expected
rsp_err1  output  1  lane 1 captured value != expected
busy  output  1  transaction in flight (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset (rst high at an edge):
  - State goes to IDLE. Settle counter = 0.
  - mux_sel_0/1 = 0 and mux_in_0/1 = 0.
  - rsp_valid = 0, rsp_data0/1 = 0, rsp_err0/1 = 0, busy = 0.
  - cmd_ready is forced 0 while rst is high.
- States: IDLE, SETTLE, RESP. cmd_ready = (state==IDLE) && !rst. busy = (state!=IDLE).
- IDLE:
  - On cmd_valid && cmd_ready at edge T: register cmd_sel0/1 onto mux_sel_0/1 and cmd_data0/1 onto mux_in_0/1.
  - Compute and register expected values: exp0 = sel0==0 ? data0 : {0, sel0}; exp1 = sel1==0 ? data1 : 3 + sel1, zero-extended to WIDTH.
  - Load counter = SETTLE_CYCLES - 1. Go to SETTLE.
  - With no handshake, all registers hold.
- SETTLE:
  - When counter == 0 at an edge: capture mux_out_0/1 into rsp_data0/1, set rsp_err0 = (mux_out_0 != exp0) and rsp_err1 = (mux_out_1 != exp1), set rsp_valid = 1, go to RESP.
  - Otherwise decrement the counter.
  - Capture happens at edge T + SETTLE_CYCLES. rsp_valid is first high in the cycle after that edge.
- RESP:
  - rsp_valid, rsp_data0/1 and rsp_err0/1 hold stable until rsp_valid && rsp_ready.
  - On that handshake edge: rsp_valid = 0, go to IDLE. rsp_data and rsp_err keep their last values.
- mux_sel and mux_in drive registers change only on a command handshake. They hold through RESP and IDLE.
- No overlap: the next command can be accepted no earlier than the cycle after the response handshake. Best-case throughput is one transaction per SETTLE_CYCLES + 2 cycles, with rsp_ready tied high.
- Inputs cmd_sel/cmd_data are sampled only on the handshake edge. Changes at other times have no effect.
- Reset mid-transaction (SETTLE or RESP): the transaction is abandoned, no response is delivered, and all outputs take reset values at that edge.
- rsp_ready asserted outside RESP is ignored.
- Expected-value arithmetic: the 2-bit code is zero-extended to WIDTH before the add, so there is no wrap at WIDTH = 8.

Test Plan:
- Nominal (SETTLE_CYCLES=2, real mux attached, rsp_ready=1): cmd sel0=0 data0=0xA5, sel1=3 data1=0x11 accepted at T -> rsp_valid high after edge T+2, rsp_data0=0xA5, rsp_data1=0x06, err0=0, err1=0; cmd_ready back high after the next edge.
- All codes sweep: sel0/sel1 = {1,2,3} -> rsp_data0 = 0x01/0x02/0x03, rsp_data1 = 0x04/0x05/0x06, no errors; mux_sel_0/1 equal the commanded codes during SETTLE.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid rises -> rsp_valid, data and err stable for all 5 cycles; cmd_valid held high with a second command -> cmd_ready stays 0 until the cycle after the rsp handshake, then the second command is accepted.
- Fault injection: bench drives mux_out_1=0x07 while sel1=2 -> rsp_data1=0x07, rsp_err1=1, rsp_err0=0.
- Reset mid-SETTLE (SETTLE_CYCLES=4, rst pulsed at T+2) -> rsp_valid never asserts, mux_sel/mux_in=0, busy=0, cmd_ready=1 the cycle after rst falls.
- SETTLE_CYCLES=1 -> capture at edge T+1; a mux_out value changed after T+1 does not alter the response.

Source files
------------

// File: rtl/mux_pair_driver_if.sv
// Bundle of command, mux-unit and response signals for the dual-lane mux driver.
// No latency of its own; pure wiring between driver and environment.
// Flow control is valid/ready on the cmd and rsp groups; mux group is level-driven.
interface mux_pair_driver_if #(
   parameter int WIDTH = 8
);
   // command side
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_sel0;
   logic [1:0]       cmd_sel1;
   logic [WIDTH-1:0] cmd_data0;
   logic [WIDTH-1:0] cmd_data1;

   // mux unit side
   logic [1:0]       mux_sel_0;
   logic [1:0]       mux_sel_1;
   logic [WIDTH-1:0] mux_in_0;
   logic [WIDTH-1:0] mux_in_1;
   logic [WIDTH-1:0] mux_out_0;
   logic [WIDTH-1:0] mux_out_1;

   // response side
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data0;
   logic [WIDTH-1:0] rsp_data1;
   logic             rsp_err0;
   logic             rsp_err1;

   // status
   logic             busy;

   // The driver block itself
   modport master (
      input  cmd_valid, cmd_sel0, cmd_sel1, cmd_data0, cmd_data1,
      output cmd_ready,
      output mux_sel_0, mux_sel_1, mux_in_0, mux_in_1,
      input  mux_out_0, mux_out_1,
      output rsp_valid, rsp_data0, rsp_data1, rsp_err0, rsp_err1,
      input  rsp_ready,
      output busy
   );

   // Command producer / mux unit / response consumer
   modport slave (
      output cmd_valid, cmd_sel0, cmd_sel1, cmd_data0, cmd_data1,
      input  cmd_ready,
      input  mux_sel_0, mux_sel_1, mux_in_0, mux_in_1,
      output mux_out_0, mux_out_1,
      input  rsp_valid, rsp_data0, rsp_data1, rsp_err0, rsp_err1,
      output rsp_ready,
      input  busy
   );
endinterface

// File: rtl/mux_pair_driver.sv
// Drives one command into the dual-lane select mux, waits a settle window, checks both lane outputs.
// Latency: capture SETTLE_CYCLES edges after command acceptance; rsp_valid visible the cycle after.
// Backpressure: response held stable until rsp_ready; no new command accepted until the response leaves.
module mux_pair_driver #(
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = 2
) (
   input logic               clk,
   input logic               rst,
   mux_pair_driver_if.master bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Counter reload so that capture lands exactly SETTLE_CYCLES edges after acceptance.
   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t           state_q;
   state_t           state_d;
   logic [3:0]       cnt_q;

   logic [1:0]       mux_sel0_q;
   logic [1:0]       mux_sel1_q;
   logic [WIDTH-1:0] mux_in0_q;
   logic [WIDTH-1:0] mux_in1_q;

   logic [WIDTH-1:0] exp0_q;
   logic [WIDTH-1:0] exp1_q;
   logic [WIDTH-1:0] exp0_d;
   logic [WIDTH-1:0] exp1_d;

   logic             rsp_valid_q;
   logic [WIDTH-1:0] rsp_data0_q;
   logic [WIDTH-1:0] rsp_data1_q;
   logic             rsp_err0_q;
   logic             rsp_err1_q;

   logic             cmd_ready;
   logic             cmd_fire;
   logic             rsp_fire;
   logic             capture;

   assign cmd_fire = bus.cmd_valid && cmd_ready;
   assign rsp_fire = rsp_valid_q && bus.rsp_ready;
   assign capture  = (state_q == SETTLE) && (cnt_q == 4'd0);

   // Expected lane values: codes are zero-extended before the lane-1 offset add, so no wrap.
   always_comb begin
      exp0_d = (bus.cmd_sel0 == 2'd0) ? bus.cmd_data0 : WIDTH'(bus.cmd_sel0);
      exp1_d = (bus.cmd_sel1 == 2'd0) ? bus.cmd_data1
                                      : WIDTH'(bus.cmd_sel1) + WIDTH'(3);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: one command, one settle window, one response; never overlapping.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cmd_fire) state_d = SETTLE;
         SETTLE:  if (capture)  state_d = RESP;
         RESP:    if (rsp_fire) state_d = IDLE;
         default:               state_d = IDLE;
      endcase
   end

   // State-derived outputs; ready is masked during reset so nothing is accepted on a reset edge.
   always_comb begin
      cmd_ready = (state_q == IDLE) && !rst;
      bus.cmd_ready = cmd_ready;
      bus.busy      = (state_q != IDLE);
   end

   // Settle counter: loaded on acceptance, counts down to the capture edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 4'd0;
      end else if (cmd_fire) begin
         cnt_q <= CNT_LOAD;
      end else if ((state_q == SETTLE) && (cnt_q != 4'd0)) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   // Mux drive registers: only a command handshake changes them, they hold through RESP and IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         mux_sel0_q <= 2'd0;
         mux_sel1_q <= 2'd0;
         mux_in0_q  <= '0;
         mux_in1_q  <= '0;
      end else if (cmd_fire) begin
         mux_sel0_q <= bus.cmd_sel0;
         mux_sel1_q <= bus.cmd_sel1;
         mux_in0_q  <= bus.cmd_data0;
         mux_in1_q  <= bus.cmd_data1;
      end
   end

   // Expected values are latched alongside the command so the capture compare is register-to-register.
   always_ff @(posedge clk) begin
      if (rst) begin
         exp0_q <= '0;
         exp1_q <= '0;
      end else if (cmd_fire) begin
         exp0_q <= exp0_d;
         exp1_q <= exp1_d;
      end
   end

   // Response registers: capture at the end of the settle window; data/err outlive the handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_data0_q <= '0;
         rsp_data1_q <= '0;
         rsp_err0_q  <= 1'b0;
         rsp_err1_q  <= 1'b0;
      end else if (capture) begin
         rsp_valid_q <= 1'b1;
         rsp_data0_q <= bus.mux_out_0;
         rsp_data1_q <= bus.mux_out_1;
         rsp_err0_q  <= (bus.mux_out_0 != exp0_q);
         rsp_err1_q  <= (bus.mux_out_1 != exp1_q);
      end else if (rsp_fire) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign bus.mux_sel_0 = mux_sel0_q;
   assign bus.mux_sel_1 = mux_sel1_q;
   assign bus.mux_in_0  = mux_in0_q;
   assign bus.mux_in_1  = mux_in1_q;

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data0 = rsp_data0_q;
   assign bus.rsp_data1 = rsp_data1_q;
   assign bus.rsp_err0  = rsp_err0_q;
   assign bus.rsp_err1  = rsp_err1_q;

   // A pending response must not move while the consumer stalls.
   a_rsp_hold: assert property (@(posedge clk) disable iff (rst)
      (rsp_valid_q && !bus.rsp_ready) |=>
         (rsp_valid_q && $stable(rsp_data0_q) && $stable(rsp_data1_q)
          && $stable(rsp_err0_q) && $stable(rsp_err1_q)));

   // Response only ever presented in RESP.
   a_rsp_in_resp: assert property (@(posedge clk) disable iff (rst)
      rsp_valid_q |-> (state_q == RESP));

   // Mux drive only changes on an accepted command.
   a_mux_hold: assert property (@(posedge clk) disable iff (rst)
      !cmd_fire |=> ($stable(mux_sel0_q) && $stable(mux_sel1_q)
                     && $stable(mux_in0_q) && $stable(mux_in1_q)));

endmodule

// File: tb/tb_mux_pair_driver.sv
// Scoreboard bench: three drivers (settle 2 / 4 / 1) against a behavioural mux and directed stimulus.
// Expected responses are queued at command acceptance and popped when the response handshake occurs.
// Consumer backpressure is applied explicitly in the stall and short-settle scenarios.
module tb_mux_pair_driver;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] d0;
      logic [W-1:0] d1;
      logic         e0;
      logic         e1;
   } rsp_t;

   logic clk;
   logic rst_a, rst_b, rst_c;
   logic a_fault;
   logic [W-1:0] c_out0, c_out1;

   int n_chk  = 0;
   int n_fail = 0;
   rsp_t sb_q[$];

   mux_pair_driver_if #(.WIDTH(W)) a_if();
   mux_pair_driver_if #(.WIDTH(W)) b_if();
   mux_pair_driver_if #(.WIDTH(W)) c_if();

   mux_pair_driver #(.WIDTH(W), .SETTLE_CYCLES(2)) u_dut_a (.clk(clk), .rst(rst_a), .bus(a_if.master));
   mux_pair_driver #(.WIDTH(W), .SETTLE_CYCLES(4)) u_dut_b (.clk(clk), .rst(rst_b), .bus(b_if.master));
   mux_pair_driver #(.WIDTH(W), .SETTLE_CYCLES(1)) u_dut_c (.clk(clk), .rst(rst_c), .bus(c_if.master));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural dual-lane select mux
   function automatic logic [W-1:0] mux0_f(input logic [1:0] s, input logic [W-1:0] d);
      return (s == 2'd0) ? d : {6'd0, s};
   endfunction

   function automatic logic [W-1:0] mux1_f(input logic [1:0] s, input logic [W-1:0] d);
      return (s == 2'd0) ? d : (8'd3 + {6'd0, s});
   endfunction

   assign a_if.mux_out_0 = mux0_f(a_if.mux_sel_0, a_if.mux_in_0);
   assign a_if.mux_out_1 = (a_fault && a_if.mux_sel_1 == 2'd2) ? 8'h07
                                                              : mux1_f(a_if.mux_sel_1, a_if.mux_in_1);
   assign b_if.mux_out_0 = mux0_f(b_if.mux_sel_0, b_if.mux_in_0);
   assign b_if.mux_out_1 = mux1_f(b_if.mux_sel_1, b_if.mux_in_1);
   assign c_if.mux_out_0 = c_out0;
   assign c_if.mux_out_1 = c_out1;

   // Expected response: the spec's expected value per lane, the lane output the attached mux produces
   function automatic rsp_t model_rsp(input logic [1:0] s0, input logic [W-1:0] d0,
                                      input logic [1:0] s1, input logic [W-1:0] d1,
                                      input logic fault);
      rsp_t r;
      logic [W-1:0] e0, e1, o0, o1;
      e0 = (s0 == 2'd0) ? d0 : {6'd0, s0};
      e1 = (s1 == 2'd0) ? d1 : (8'd3 + {6'd0, s1});
      o0 = e0;
      o1 = (fault && s1 == 2'd2) ? 8'h07 : e1;
      r.d0 = o0;
      r.d1 = o1;
      r.e0 = (o0 != e0);
      r.e1 = (o1 != e1);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Response monitor for DUT A: pop and compare on every response handshake
   always @(negedge clk) begin : sb_mon
      rsp_t e;
      if (!rst_a && a_if.rsp_valid && a_if.rsp_ready) begin
         if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("rsp_data0", 32'(a_if.rsp_data0), 32'(e.d0));
            check("rsp_data1", 32'(a_if.rsp_data1), 32'(e.d1));
            check("rsp_err0",  32'(a_if.rsp_err0),  32'(e.e0));
            check("rsp_err1",  32'(a_if.rsp_err1),  32'(e.e1));
         end
      end
   end

   // Present a command to A; returns 1ns after the accepting edge with inputs scrambled
   task automatic send_a(input logic [1:0] s0, input logic [W-1:0] d0,
                         input logic [1:0] s1, input logic [W-1:0] d1);
      int n = 0;
      a_if.cmd_sel0  = s0;
      a_if.cmd_data0 = d0;
      a_if.cmd_sel1  = s1;
      a_if.cmd_data1 = d1;
      a_if.cmd_valid = 1'b1;
      @(negedge clk);
      while (!a_if.cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("a_accept_timeout", 32'd1, 32'd0);
      sb_q.push_back(model_rsp(s0, d0, s1, d1, a_fault));
      @(posedge clk);
      #1;
      a_if.cmd_valid = 1'b0;
      a_if.cmd_sel0  = 2'($urandom);
      a_if.cmd_sel1  = 2'($urandom);
      a_if.cmd_data0 = 8'($urandom);
      a_if.cmd_data1 = 8'($urandom);
   endtask

   task automatic wait_idle_a();
      int n = 0;
      @(negedge clk);
      while (a_if.busy && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) check("a_idle_timeout", 32'd1, 32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      int vcount;
      rsp_t bp;
      logic [1:0] s1;

      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      a_fault = 1'b0;
      c_out0 = '0; c_out1 = '0;
      a_if.cmd_valid = 1'b0; a_if.cmd_sel0 = 2'd1; a_if.cmd_sel1 = 2'd2;
      a_if.cmd_data0 = 8'h5A; a_if.cmd_data1 = 8'h3C; a_if.rsp_ready = 1'b1;
      b_if.cmd_valid = 1'b0; b_if.cmd_sel0 = 2'd0; b_if.cmd_sel1 = 2'd0;
      b_if.cmd_data0 = '0; b_if.cmd_data1 = '0; b_if.rsp_ready = 1'b1;
      c_if.cmd_valid = 1'b0; c_if.cmd_sel0 = 2'd0; c_if.cmd_sel1 = 2'd0;
      c_if.cmd_data0 = '0; c_if.cmd_data1 = '0; c_if.rsp_ready = 1'b0;

      // Reset state, with a command offered during reset that must be ignored
      a_if.cmd_valid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", 32'(a_if.cmd_ready), 32'd0);
      check("rst_busy",      32'(a_if.busy),      32'd0);
      check("rst_rsp_valid", 32'(a_if.rsp_valid), 32'd0);
      check("rst_mux_sel_0", 32'(a_if.mux_sel_0), 32'd0);
      check("rst_mux_sel_1", 32'(a_if.mux_sel_1), 32'd0);
      check("rst_mux_in_0",  32'(a_if.mux_in_0),  32'd0);
      check("rst_mux_in_1",  32'(a_if.mux_in_1),  32'd0);
      check("rst_rsp_data0", 32'(a_if.rsp_data0), 32'd0);
      check("rst_rsp_err1",  32'(a_if.rsp_err1),  32'd0);
      a_if.cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      @(negedge clk);
      check("post_rst_cmd_ready", 32'(a_if.cmd_ready), 32'd1);

      // Nominal transaction with cycle-accurate timing
      @(posedge clk);
      #1;
      send_a(2'd0, 8'hA5, 2'd3, 8'h11);
      @(negedge clk);
      check("nom_vld_T0",   32'(a_if.rsp_valid), 32'd0);
      check("nom_busy_T0",  32'(a_if.busy),      32'd1);
      check("nom_rdy_T0",   32'(a_if.cmd_ready), 32'd0);
      check("nom_sel1_T0",  32'(a_if.mux_sel_1), 32'd3);
      check("nom_in0_T0",   32'(a_if.mux_in_0),  32'hA5);
      @(negedge clk);
      check("nom_vld_T1",   32'(a_if.rsp_valid), 32'd0);
      @(negedge clk);
      check("nom_vld_T2",   32'(a_if.rsp_valid), 32'd1);
      @(negedge clk);
      check("nom_vld_T3",   32'(a_if.rsp_valid), 32'd0);
      check("nom_rdy_T3",   32'(a_if.cmd_ready), 32'd1);
      check("nom_sel1_hold", 32'(a_if.mux_sel_1), 32'd3);

      // Code sweep on both lanes; selects visible on the mux during SETTLE
      for (int s = 1; s <= 3; s++) begin
         s1 = 2'((s % 3) + 1);
         @(posedge clk);
         #1;
         send_a(2'(s), 8'($urandom), s1, 8'($urandom));
         @(negedge clk);
         check("sweep_sel0", 32'(a_if.mux_sel_0), 32'(s));
         check("sweep_sel1", 32'(a_if.mux_sel_1), 32'(s1));
         wait_idle_a();
      end

      // Data pass-through with random operands
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         send_a(2'd0, 8'($urandom), 2'd0, 8'($urandom));
         wait_idle_a();
      end

      // Backpressure: stall the response, second command held pending
      @(posedge clk);
      #1;
      a_if.rsp_ready = 1'b0;
      send_a(2'd2, 8'($urandom), 2'd1, 8'($urandom));
      n = 0;
      @(negedge clk);
      while (!a_if.rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("bp_rsp_timeout", 32'd1, 32'd0);
      bp = sb_q[0];
      a_if.cmd_sel0  = 2'd3; a_if.cmd_data0 = 8'h77;
      a_if.cmd_sel1  = 2'd0; a_if.cmd_data1 = 8'hE1;
      a_if.cmd_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check("bp_valid", 32'(a_if.rsp_valid), 32'd1);
         check("bp_data0", 32'(a_if.rsp_data0), 32'(bp.d0));
         check("bp_data1", 32'(a_if.rsp_data1), 32'(bp.d1));
         check("bp_err0",  32'(a_if.rsp_err0),  32'(bp.e0));
         check("bp_err1",  32'(a_if.rsp_err1),  32'(bp.e1));
         check("bp_cmd_ready", 32'(a_if.cmd_ready), 32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      a_if.rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_rdy_before_hs", 32'(a_if.cmd_ready), 32'd0);
      @(negedge clk);
      check("bp_rdy_after_hs", 32'(a_if.cmd_ready), 32'd1);
      check("bp_vld_after_hs", 32'(a_if.rsp_valid), 32'd0);
      sb_q.push_back(model_rsp(2'd3, 8'h77, 2'd0, 8'hE1, a_fault));
      @(posedge clk);
      #1;
      a_if.cmd_valid = 1'b0;
      @(negedge clk);
      check("bp_second_busy", 32'(a_if.busy), 32'd1);
      wait_idle_a();

      // Fault injection on lane 1
      a_fault = 1'b1;
      @(posedge clk);
      #1;
      send_a(2'd1, 8'($urandom), 2'd2, 8'($urandom));
      wait_idle_a();
      a_fault = 1'b0;

      // Reset in the middle of a long settle window (DUT B)
      @(posedge clk);
      #1;
      b_if.cmd_sel0 = 2'd3; b_if.cmd_data0 = 8'hC3;
      b_if.cmd_sel1 = 2'd3; b_if.cmd_data1 = 8'h3C;
      b_if.cmd_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!b_if.cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("b_accept_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
      b_if.cmd_valid = 1'b0;
      @(negedge clk);
      check("b_busy_T0", 32'(b_if.busy),      32'd1);
      check("b_sel0_T0", 32'(b_if.mux_sel_0), 32'd3);
      @(posedge clk);
      #1;
      rst_b = 1'b1;
      @(posedge clk);
      #1;
      rst_b = 1'b0;
      @(negedge clk);
      check("b_rst_sel0",  32'(b_if.mux_sel_0), 32'd0);
      check("b_rst_sel1",  32'(b_if.mux_sel_1), 32'd0);
      check("b_rst_in0",   32'(b_if.mux_in_0),  32'd0);
      check("b_rst_in1",   32'(b_if.mux_in_1),  32'd0);
      check("b_rst_busy",  32'(b_if.busy),      32'd0);
      check("b_rst_ready", 32'(b_if.cmd_ready), 32'd1);
      vcount = 0;
      for (int k = 0; k < 10; k++) begin
         if (b_if.rsp_valid) vcount++;
         @(negedge clk);
      end
      check("b_no_rsp", 32'(vcount), 32'd0);

      // Single-cycle settle: capture at T+1, later mux changes must not leak in (DUT C)
      c_out0 = 8'h3C;
      c_out1 = 8'h04;
      @(posedge clk);
      #1;
      c_if.cmd_sel0 = 2'd0; c_if.cmd_data0 = 8'h3C;
      c_if.cmd_sel1 = 2'd1; c_if.cmd_data1 = 8'h99;
      c_if.cmd_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!c_if.cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("c_accept_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1;
      c_if.cmd_valid = 1'b0;
      @(negedge clk);
      check("c_vld_T0", 32'(c_if.rsp_valid), 32'd0);
      @(posedge clk);
      #1;
      c_out0 = 8'h55;
      c_out1 = 8'hAA;
      @(negedge clk);
      check("c_vld_T1",  32'(c_if.rsp_valid), 32'd1);
      check("c_data0",   32'(c_if.rsp_data0), 32'h3C);
      check("c_data1",   32'(c_if.rsp_data1), 32'h04);
      check("c_err0",    32'(c_if.rsp_err0),  32'd0);
      check("c_err1",    32'(c_if.rsp_err1),  32'd0);
      @(negedge clk);
      check("c_data0_hold", 32'(c_if.rsp_data0), 32'h3C);
      check("c_data1_hold", 32'(c_if.rsp_data1), 32'h04);
      @(posedge clk);
      #1;
      c_if.rsp_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (c_if.busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("c_idle_timeout", 32'd1, 32'd0);
      check("c_vld_done", 32'(c_if.rsp_valid), 32'd0);

      repeat (2) @(negedge clk);
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
